// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Takes one instruction at a time over ex_valid_i/mem_ready_o. Loads and
// stores go out on a req/gnt/rvalid data-memory port with row-aligned write
// data and byte strobes, and the raw 64-bit read row is captured. Every field
// that writeback needs is registered and presented with a one-cycle
// wb_valid_o pulse. Load extraction and extension happen in writeback.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   ex_valid_i/mem_ready_o  handshake from execute
//   *_i (execute side)      ALU result/address, store data, forwarded fields
//   dmem_*                  data-memory request/grant/response port
//   wb_valid_o, *_o         registered writeback fields and valid pulse
//   misalign_o              misaligned access flag, pulses with wb_valid_o
//
// state | meaning
// IDLE  | ready for a new instruction
// REQ   | memory request held on dmem_* until dmem_gnt_i
// RSP   | granted; waiting for dmem_rvalid_i, then one cycle to writeback
module mem_stage #(
  parameter int DMEM_ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ex_valid_i,
  output logic                   mem_ready_o,
  input  logic [63:0]            alu_res_i,
  input  logic [63:0]            store_data_i,
  input  logic [63:0]            instr_imm_i,
  input  logic [63:0]            pc_val_i,
  input  logic [1:0]             rf_wr_data_src_i,
  input  logic [1:0]             data_byte_en_i,
  input  logic                   data_zero_extnd_i,
  input  logic                   data_req_i,
  input  logic                   data_wr_i,
  input  logic [4:0]             rd_addr_i,
  input  logic                   rf_wr_en_i,
  output logic                   dmem_req_o,
  output logic                   dmem_wr_o,
  output logic [DMEM_ADDR_W-1:0] dmem_addr_o,
  output logic [63:0]            dmem_wdata_o,
  output logic [7:0]             dmem_be_o,
  input  logic                   dmem_gnt_i,
  input  logic                   dmem_rvalid_i,
  input  logic [63:0]            dmem_rdata_i,
  output logic                   wb_valid_o,
  output logic [63:0]            alu_res_o,
  output logic [63:0]            data_mem_rd_o,
  output logic [63:0]            instr_imm_o,
  output logic [63:0]            pc_val_o,
  output logic [1:0]             rf_wr_data_src_o,
  output logic [1:0]             data_byte_en_o,
  output logic                   data_zero_extnd_o,
  output logic [2:0]             data_mem_row_idx_o,
  output logic [4:0]             rd_addr_o,
  output logic                   rf_wr_en_o,
  output logic                   misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t state, state_nxt;

  logic                   accept;
  logic                   misalign;
  logic                   mem_go;
  logic                   rsp_got;   // response seen; writeback on next edge
  logic                   rsp_take;
  logic [2:0]             row_idx;
  logic [2:0]             align_mask;
  logic [7:0]             be_base;
  logic [7:0]             be_calc;
  logic [63:0]            wdata_calc;

  logic                   req_wr;
  logic [DMEM_ADDR_W-1:0] req_addr;
  logic [63:0]            req_wdata;
  logic [7:0]             req_be;

  logic                   unused_addr_bits;
  assign unused_addr_bits = ^alu_res_i[63:DMEM_ADDR_W+3];

  // Gated with reset so every output reads 0 while reset is held.
  assign mem_ready_o = (state == IDLE) & ~reset;
  assign accept      = ex_valid_i & mem_ready_o;
  assign row_idx     = alu_res_i[2:0];

  always_comb begin
    align_mask = 3'b111;
    be_base    = 8'hFF;
    case (data_byte_en_i)
      2'd0: begin align_mask = 3'b000; be_base = 8'h01; end
      2'd1: begin align_mask = 3'b001; be_base = 8'h03; end
      2'd2: begin align_mask = 3'b011; be_base = 8'h0F; end
      default: begin align_mask = 3'b111; be_base = 8'hFF; end
    endcase
  end

  assign misalign   = data_req_i & (|(row_idx & align_mask));
  assign mem_go     = data_req_i & ~misalign;
  assign be_calc    = be_base << row_idx;
  assign wdata_calc = store_data_i << {row_idx, 3'b000};
  assign rsp_take   = (state == RSP) & ~rsp_got & dmem_rvalid_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && mem_go) state_nxt = REQ;
      REQ:     if (dmem_gnt_i)       state_nxt = RSP;
      RSP:     if (rsp_got)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dmem_* are only non-zero while a request is outstanding, so non-memory
  // traffic and reset both leave the port quiet.
  assign dmem_req_o   = (state == REQ);
  assign dmem_wr_o    = dmem_req_o & req_wr;
  assign dmem_addr_o  = dmem_req_o ? req_addr  : '0;
  assign dmem_wdata_o = dmem_req_o ? req_wdata : '0;
  assign dmem_be_o    = dmem_req_o ? req_be    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_got            <= 1'b0;
      req_wr             <= 1'b0;
      req_addr           <= '0;
      req_wdata          <= '0;
      req_be             <= '0;
      wb_valid_o         <= 1'b0;
      misalign_o         <= 1'b0;
      alu_res_o          <= '0;
      data_mem_rd_o      <= '0;
      instr_imm_o        <= '0;
      pc_val_o           <= '0;
      rf_wr_data_src_o   <= '0;
      data_byte_en_o     <= '0;
      data_zero_extnd_o  <= 1'b0;
      data_mem_row_idx_o <= '0;
      rd_addr_o          <= '0;
      rf_wr_en_o         <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      rsp_got    <= rsp_take;

      if (accept) begin
        alu_res_o          <= alu_res_i;
        instr_imm_o        <= instr_imm_i;
        pc_val_o           <= pc_val_i;
        rf_wr_data_src_o   <= rf_wr_data_src_i;
        data_byte_en_o     <= data_byte_en_i;
        data_zero_extnd_o  <= data_zero_extnd_i;
        data_mem_row_idx_o <= row_idx;
        rd_addr_o          <= rd_addr_i;
        rf_wr_en_o         <= rf_wr_en_i & ~misalign & ~(data_req_i & data_wr_i);
        if (mem_go) begin
          req_wr    <= data_wr_i;
          req_addr  <= alu_res_i[DMEM_ADDR_W+2:3];
          req_wdata <= wdata_calc;
          req_be    <= be_calc;
        end else begin
          // Non-memory or misaligned: nothing goes to memory, write back now.
          wb_valid_o <= 1'b1;
          misalign_o <= misalign;
        end
      end

      // Store acks leave the previously captured row untouched.
      if (rsp_take && !req_wr) data_mem_rd_o <= dmem_rdata_i;

      if (state == RSP && rsp_got) wb_valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        mem_ready_o;
  logic [63:0] alu_res_i = '0, store_data_i = '0, instr_imm_i = '0, pc_val_i = '0;
  logic [1:0]  rf_wr_data_src_i = '0, data_byte_en_i = '0;
  logic        data_zero_extnd_i = 1'b0, data_req_i = 1'b0, data_wr_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic        rf_wr_en_i = 1'b0;
  logic        dmem_req_o, dmem_wr_o;
  logic [31:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [63:0] dmem_rdata_i = '0;
  logic        wb_valid_o;
  logic [63:0] alu_res_o, data_mem_rd_o, instr_imm_o, pc_val_o;
  logic [1:0]  rf_wr_data_src_o, data_byte_en_o;
  logic        data_zero_extnd_o;
  logic [2:0]  data_mem_row_idx_o;
  logic [4:0]  rd_addr_o;
  logic        rf_wr_en_o, misalign_o;

  mem_stage #(.DMEM_ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .ex_valid_i(ex_valid_i), .mem_ready_o(mem_ready_o),
    .alu_res_i(alu_res_i), .store_data_i(store_data_i), .instr_imm_i(instr_imm_i),
    .pc_val_i(pc_val_i), .rf_wr_data_src_i(rf_wr_data_src_i),
    .data_byte_en_i(data_byte_en_i), .data_zero_extnd_i(data_zero_extnd_i),
    .data_req_i(data_req_i), .data_wr_i(data_wr_i), .rd_addr_i(rd_addr_i),
    .rf_wr_en_i(rf_wr_en_i), .dmem_req_o(dmem_req_o), .dmem_wr_o(dmem_wr_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .alu_res_o(alu_res_o), .data_mem_rd_o(data_mem_rd_o),
    .instr_imm_o(instr_imm_o), .pc_val_o(pc_val_o), .rf_wr_data_src_o(rf_wr_data_src_o),
    .data_byte_en_o(data_byte_en_o), .data_zero_extnd_o(data_zero_extnd_o),
    .data_mem_row_idx_o(data_mem_row_idx_o), .rd_addr_o(rd_addr_o),
    .rf_wr_en_o(rf_wr_en_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] alu, rd_mem, imm, pc;
    logic [1:0]  src, size;
    logic        zext;
    logic [2:0]  row;
    logic [4:0]  rd;
    logic        wen, mis;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          wb_count = 0;
  int          n_push = 0;
  logic [63:0] last_rd = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wb_valid_o) wb_count <= wb_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one instruction and queue what writeback should see for it.
  task automatic issue(input logic [63:0] alu, input logic [63:0] sd, input logic [63:0] imm,
                       input logic [63:0] pc, input logic [1:0] src, input logic [1:0] size,
                       input logic zext, input logic req, input logic wr, input logic [4:0] rd,
                       input logic wen, input logic exp_wen, input logic exp_mis,
                       input logic [63:0] exp_rd_mem);
    exp_t e;
    alu_res_i = alu; store_data_i = sd; instr_imm_i = imm; pc_val_i = pc;
    rf_wr_data_src_i = src; data_byte_en_i = size; data_zero_extnd_i = zext;
    data_req_i = req; data_wr_i = wr; rd_addr_i = rd; rf_wr_en_i = wen;
    ex_valid_i = 1'b1;
    e.alu = alu; e.rd_mem = exp_rd_mem; e.imm = imm; e.pc = pc; e.src = src; e.size = size;
    e.zext = zext; e.row = alu[2:0]; e.rd = rd; e.wen = exp_wen; e.mis = exp_mis;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic accept_step();
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    ex_valid_i = 1'b0;
    data_req_i = 1'b0;
    data_wr_i  = 1'b0;
  endtask

  task automatic check_wb(input string tag);
    exp_t e;
    chk({tag, "_wb_valid"}, {63'd0, wb_valid_o}, 64'd1);
    chk({tag, "_sb_nonempty"}, {63'd0, sb.size() != 0}, 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_alu_res"}, alu_res_o, e.alu);
      chk({tag, "_mem_rd"}, data_mem_rd_o, e.rd_mem);
      chk({tag, "_imm"}, instr_imm_o, e.imm);
      chk({tag, "_pc"}, pc_val_o, e.pc);
      chk({tag, "_src"}, {62'd0, rf_wr_data_src_o}, {62'd0, e.src});
      chk({tag, "_size"}, {62'd0, data_byte_en_o}, {62'd0, e.size});
      chk({tag, "_zext"}, {63'd0, data_zero_extnd_o}, {63'd0, e.zext});
      chk({tag, "_row"}, {61'd0, data_mem_row_idx_o}, {61'd0, e.row});
      chk({tag, "_rd"}, {59'd0, rd_addr_o}, {59'd0, e.rd});
      chk({tag, "_wen"}, {63'd0, rf_wr_en_o}, {63'd0, e.wen});
      chk({tag, "_misalign"}, {63'd0, misalign_o}, {63'd0, e.mis});
    end
  endtask

  task automatic wait_wb(input string tag, input int exp_lat);
    int n = 0;
    while (!wb_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(cyc - acc_cyc + 1), 64'(exp_lat));
    check_wb(tag);
  endtask

  // Plays the memory side: grants after gdly waiting cycles (with stray
  // rvalids during REQ that must be ignored), then responds one cycle later.
  task automatic mem_txn(input string tag, input logic [31:0] eaddr, input logic [7:0] ebe,
                         input logic [63:0] ewdata, input logic ewr, input int gdly,
                         input logic [63:0] rdata);
    for (int i = 0; i <= gdly; i++) begin
      chk({tag, "_req"}, {63'd0, dmem_req_o}, 64'd1);
      chk({tag, "_addr"}, {32'd0, dmem_addr_o}, {32'd0, eaddr});
      chk({tag, "_be"}, {56'd0, dmem_be_o}, {56'd0, ebe});
      chk({tag, "_wdata"}, dmem_wdata_o, ewdata);
      chk({tag, "_wr"}, {63'd0, dmem_wr_o}, {63'd0, ewr});
      if (i == gdly) begin
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
      end else begin
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
      end
      @(posedge clk);
      @(negedge clk);
    end
    dmem_gnt_i = 1'b0;
    chk({tag, "_req_drop"}, {63'd0, dmem_req_o}, 64'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
  endtask

  initial begin
    int wbc;

    // Reset state
    @(negedge clk);
    chk("rst_ready", {63'd0, mem_ready_o}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid_o}, 64'd0);
    chk("rst_dmem_req", {63'd0, dmem_req_o}, 64'd0);
    chk("rst_alu_res", alu_res_o, 64'd0);
    chk("rst_mem_rd", data_mem_rd_o, 64'd0);
    chk("rst_misalign", {63'd0, misalign_o}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, mem_ready_o}, 64'd1);

    // ALU op
    issue(64'h1234, 64'h0, 64'h77, 64'h8000_0000, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 5'd5,
          1'b1, 1'b1, 1'b0, last_rd);
    accept_step();
    chk("alu_dmem_req", {63'd0, dmem_req_o}, 64'd0);
    wait_wb("alu", 1);

    // Load D at 0x1000, immediate grant
    @(negedge clk);
    issue(64'h1000, 64'h0, 64'h10, 64'h8000_0004, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 5'd6,
          1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
    accept_step();
    mem_txn("ld_d", 32'h200, 8'hFF, 64'h0, 1'b0, 0, 64'hDEAD_BEEF_CAFE_F00D);
    last_rd = 64'hDEAD_BEEF_CAFE_F00D;
    wait_wb("ld_d", 4);

    // Store H at 0x1006, grant delayed 3 cycles
    @(negedge clk);
    issue(64'h1006, 64'hABCD, 64'h20, 64'h8000_0008, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, 5'd7,
          1'b1, 1'b0, 1'b0, last_rd);
    accept_step();
    mem_txn("st_h", 32'h200, 8'hC0, 64'hABCD_0000_0000_0000, 1'b1, 3, 64'h5555_6666_7777_8888);
    wait_wb("st_h", 7);

    // Load B at top byte of the row, zero-extend, grant after 1 wait
    @(negedge clk);
    issue(64'h300F, 64'h0, 64'h30, 64'h8000_000C, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 5'd8,
          1'b1, 1'b1, 1'b0, 64'h1122_3344_5566_7788);
    accept_step();
    mem_txn("ld_b", 32'h601, 8'h80, 64'h0, 1'b0, 1, 64'h1122_3344_5566_7788);
    last_rd = 64'h1122_3344_5566_7788;
    wait_wb("ld_b", 5);

    // Misaligned load W at 0x1002
    @(negedge clk);
    issue(64'h1002, 64'h0, 64'h40, 64'h8000_0010, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 5'd9,
          1'b1, 1'b0, 1'b1, last_rd);
    accept_step();
    chk("mis_dmem_req", {63'd0, dmem_req_o}, 64'd0);
    wait_wb("mis", 1);

    // Reset in RSP, late rvalid after release
    @(negedge clk);
    alu_res_i = 64'h2008; data_byte_en_i = 2'd3; data_req_i = 1'b1; data_wr_i = 1'b0;
    rf_wr_en_i = 1'b1; rd_addr_i = 5'd10; ex_valid_i = 1'b1;
    accept_step();
    chk("rr_req", {63'd0, dmem_req_o}, 64'd1);
    dmem_gnt_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    wbc = wb_count;
    reset = 1'b1;
    #1;
    chk("rr_req_during_rst", {63'd0, dmem_req_o}, 64'd0);
    chk("rr_alu_res_cleared", alu_res_o, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
    @(negedge clk);
    @(negedge clk);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 64'hFEED_FACE_0000_1111;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rr_no_wb", 64'(wb_count), 64'(wbc));
    chk("rr_ready", {63'd0, mem_ready_o}, 64'd1);
    chk("rr_req_after", {63'd0, dmem_req_o}, 64'd0);
    chk("rr_mem_rd", data_mem_rd_o, 64'd0);

    // Three back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      issue(64'h100 + 64'(i), 64'h0, 64'(i), 64'h9000 + 64'(4 * i), 2'(i), 2'd3, 1'b0, 1'b0,
            1'b0, 5'(11 + i), 1'b1, 1'b1, 1'b0, last_rd);
      chk("b2b_ready", {63'd0, mem_ready_o}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      check_wb("b2b");
    end
    ex_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_wb_end", {63'd0, wb_valid_o}, 64'd0);

    @(negedge clk);
    @(negedge clk);
    chk("wb_pulse_count", 64'(wb_count), 64'(n_push));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage of the RV64 core. Sits between execute and writeback.
- Accepts one instruction at a time from execute over a valid/ready handshake.
- For loads and stores, drives a request/grant/response data-memory port: aligns store data and byte strobes, and captures the raw 64-bit read row.
- Registers every field writeback consumes (ALU result, raw memory row, immediate, PC, source select, size, zero-extend flag, row index). Load extraction and sign/zero extension are done downstream in writeback.

Parameters:
DMEM_ADDR_W, 32, width of the data-memory row (64-bit word) address

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ex_valid_i  input  1  execute presents an instruction
mem_ready_o  output  1  stage can accept an instruction this cycle
alu_res_i  input  64  ALU result; effective address for loads/stores
store_data_i  input  64  rs2 value for stores, low bytes significant
instr_imm_i  input  64  immediate, forwarded
pc_val_i  input  64  PC, forwarded
rf_wr_data_src_i  input  2  writeback source select, forwarded
data_byte_en_i  input  2  access size: 0=B, 1=H, 2=W, 3=D
data_zero_extnd_i  input  1  load zero-extend flag, forwarded
data_req_i  input  1  instruction is a memory access
data_wr_i  input  1  access is a store (valid with data_req_i)
rd_addr_i  input  5  destination register
rf_wr_en_i  input  1  register-file write enable
dmem_req_o  output  1  memory request
dmem_wr_o  output  1  request is a write
dmem_addr_o  output  DMEM_ADDR_W  row address = alu_res[DMEM_ADDR_W+2:3]
dmem_wdata_o  output  64  store data shifted left by 8*row_idx
dmem_be_o  output  8  byte strobes = ((1<<(1<<size))-1) << row_idx
dmem_gnt_i  input  1  memory accepted the request
dmem_rvalid_i  input  1  response valid (read data or write ack)
dmem_rdata_i  input  64  read row
wb_valid_o  output  1  one-cycle pulse: writeback fields valid
alu_res_o, data_mem_rd_o, instr_imm_o, pc_val_o  output  64 each  registered fields for writeback
rf_wr_data_src_o  output  2  registered
data_byte_en_o  output  2  registered
data_zero_extnd_o  output  1  registered
data_mem_row_idx_o  output  3  registered alu_res[2:0]
rd_addr_o  output  5  registered
rf_wr_en_o  output  1  registered; forced to 0 on misalign and for stores
misalign_o  output  1  pulse with wb_valid_o: misaligned access detected

Behaviour:
- Reset (asynchronous): state IDLE; every output and register reads 0. mem_ready_o is 1 after reset release.
- FSM states: IDLE, REQ, RSP. mem_ready_o = (state==IDLE). Accept = ex_valid_i & mem_ready_o.
- IDLE, accept, data_req_i=0: fields are registered; wb_valid_o=1 in the next cycle (latency 1); stay in IDLE. Back-to-back acceptance is allowed every cycle.
- IDLE, accept, data_req_i=1, aligned: latch the request (addr, wdata, be, wr) and go to REQ. dmem_req_o is asserted from the next cycle.
- Alignment rule: (row_idx & ((1<<size)-1)) == 0.
- IDLE, accept, misaligned: no memory request is issued. Next cycle: wb_valid_o=1, misalign_o=1, rf_wr_en_o=0. Stay in IDLE.
- REQ: dmem_req_o=1; addr, wdata, be and wr stay stable until dmem_gnt_i. On gnt: dmem_req_o drops next cycle; go to RSP.
- RSP: wait for dmem_rvalid_i.
  - Load: on rvalid, capture dmem_rdata_i into data_mem_rd_o.
  - Store: data_mem_rd_o keeps its previous value and rf_wr_en_o=0.
  - Next cycle: wb_valid_o=1; return to IDLE. mem_ready_o goes to 1 in that same cycle.
- Minimum load/store latency with gnt in the first REQ cycle and rvalid one cycle later: wb_valid_o 4 cycles after accept.
- rvalid is never asserted in the same cycle as its gnt. rvalid in IDLE or REQ is ignored.
- Non-memory instructions: dmem_* outputs stay 0.
- wb_valid_o is 1 for exactly one cycle per accepted instruction. Field outputs hold their values until the next update.
- Reset mid-operation (REQ or RSP): dmem_req_o falls immediately and the instruction is dropped. A late rvalid after reset release is ignored.

Test Plan:
- ALU op: alu_res=0x1234, rf_wr_en=1, rd=5 -> 1 cycle later wb_valid_o=1, alu_res_o=0x1234, rd_addr_o=5, dmem_req_o never 1.
- Load D at 0x1000, gnt on first REQ cycle, rvalid+rdata=0xDEADBEEFCAFEF00D next cycle -> dmem_addr_o=0x200, dmem_be_o=0xFF, data_mem_rd_o=0xDEADBEEFCAFEF00D, row_idx_o=0, wb_valid_o 4 cycles after accept.
- Store H at 0x1006, store_data=0xABCD, gnt delayed 3 cycles -> dmem_be_o=0xC0, dmem_wdata_o=0xABCD<<48, req/addr stable 3 cycles, rf_wr_en_o=0 on wb pulse.
- Load W at 0x1002 -> no dmem_req_o, next cycle wb_valid_o=1, misalign_o=1, rf_wr_en_o=0.
- Reset asserted in RSP, then rvalid 2 cycles after release -> dmem_req_o=0, no wb_valid_o, mem_ready_o=1.
- Three back-to-back ALU ops -> three consecutive wb_valid_o pulses, mem_ready_o held 1.
